// File: rtl/halloween_opcode_sequencer.sv
// Channel sequencer for the decoration controller. It walks NCH opcode channels and presents each
// non-zero opcode over a valid/ready handshake, with a dwell hold, an in-band restart and a wrap strobe.
module halloween_opcode_sequencer #(
  parameter int              NCH    = 4,
  parameter int              OPW    = 4,
  parameter int              DWELLW = 8,
  parameter logic [OPW-1:0]  RST_OP = 4'b0001,
  localparam int             IDXW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                on,
  input  logic [NCH*OPW-1:0]  chan_data,
  input  logic [DWELLW-1:0]   dwell,
  input  logic                op_ready,
  output logic                op_valid,
  output logic [OPW-1:0]      opcode,
  output logic [IDXW-1:0]     chan_idx,
  output logic                busy,
  output logic                wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DWELL = 2'd3
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  state_t              state_r, state_s;
  logic                op_valid_r, op_valid_s;
  logic [OPW-1:0]      opcode_r, opcode_s;
  logic [IDXW-1:0]     chan_idx_r, chan_idx_s;
  logic                busy_r, busy_s;
  logic                wrap_r, wrap_s;
  logic [DWELLW-1:0]   timer_r, timer_s;
  logic [OPW-1:0]      chan_op_s;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
    if (idx == LAST_IDX) begin
      next_idx = {IDXW{1'b0}};
    end else begin
      next_idx = idx + IDXW'(1);
    end
  endfunction

  // Select the opcode of the currently addressed channel
  always_comb begin
    chan_op_s = chan_data[int'(chan_idx_r) * OPW +: OPW];
  end

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    op_valid_s = op_valid_r;
    opcode_s   = opcode_r;
    chan_idx_s = chan_idx_r;
    timer_s    = timer_r;
    wrap_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        chan_idx_s = {IDXW{1'b0}};
        timer_s    = {DWELLW{1'b0}};
        if (on) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!on) begin
          state_s    = ST_IDLE;
          chan_idx_s = {IDXW{1'b0}};
        end else if (chan_op_s == {OPW{1'b0}}) begin
          chan_idx_s = next_idx(chan_idx_r);
          wrap_s     = (chan_idx_r == LAST_IDX);
        end else begin
          opcode_s   = chan_op_s;
          op_valid_s = 1'b1;
          state_s    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // op_valid is never withdrawn here; a dropped 'on' only takes effect at acceptance
        if (op_valid_r && op_ready) begin
          op_valid_s = 1'b0;
          if (!on) begin
            state_s    = ST_IDLE;
            chan_idx_s = {IDXW{1'b0}};
          end else if (opcode_r == RST_OP) begin
            state_s    = ST_LOAD;
            chan_idx_s = {IDXW{1'b0}};
          end else if (dwell == {DWELLW{1'b0}}) begin
            state_s    = ST_LOAD;
            chan_idx_s = next_idx(chan_idx_r);
            wrap_s     = (chan_idx_r == LAST_IDX);
          end else begin
            state_s = ST_DWELL;
            timer_s = dwell;
          end
        end else begin
          op_valid_s = 1'b1;
        end
      end
      ST_DWELL: begin
        if (!on) begin
          state_s    = ST_IDLE;
          chan_idx_s = {IDXW{1'b0}};
          timer_s    = {DWELLW{1'b0}};
        end else if (timer_r == DWELLW'(1)) begin
          state_s    = ST_LOAD;
          timer_s    = {DWELLW{1'b0}};
          chan_idx_s = next_idx(chan_idx_r);
          wrap_s     = (chan_idx_r == LAST_IDX);
        end else begin
          timer_s = timer_r - DWELLW'(1);
        end
      end
      default: begin
        state_s    = ST_IDLE;
        op_valid_s = 1'b0;
        chan_idx_s = {IDXW{1'b0}};
        timer_s    = {DWELLW{1'b0}};
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      op_valid_r <= 1'b0;
      opcode_r   <= {OPW{1'b0}};
      chan_idx_r <= {IDXW{1'b0}};
      busy_r     <= 1'b0;
      wrap_r     <= 1'b0;
      timer_r    <= {DWELLW{1'b0}};
    end else begin
      state_r    <= state_s;
      op_valid_r <= op_valid_s;
      opcode_r   <= opcode_s;
      chan_idx_r <= chan_idx_s;
      busy_r     <= busy_s;
      wrap_r     <= wrap_s;
      timer_r    <= timer_s;
    end
  end

  assign op_valid = op_valid_r;
  assign opcode   = opcode_r;
  assign chan_idx = chan_idx_r;
  assign busy     = busy_r;
  assign wrap     = wrap_r;

endmodule
